// File: rtl/lab2_operand_entry.sv
// Operand entry for the lab2 adder: synchronizes switches and a debounced
// enter button, then steps through addend capture, augend capture and show.
module lab2_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       btn,
  output logic [1:0] addend,
  output logic       augend,
  output logic       operands_valid,
  output logic [1:0] state_led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTER_ADDEND = 2'b00,
    ENTER_AUGEND = 2'b01,
    SHOW         = 2'b10
  } state_e;

  logic [1:0]    sw_sync1_q, sw_sync1_d;
  logic [1:0]    sw_sync2_q, sw_sync2_d;
  logic          btn_sync1_q, btn_sync1_d;
  logic          btn_sync2_q, btn_sync2_d;
  logic          btn_stable_q, btn_stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [1:0]    addend_q, addend_d;
  logic          augend_q, augend_d;
  logic          valid_q, valid_d;
  logic          press;

  always_comb begin
    sw_sync1_d   = sw;
    sw_sync2_d   = sw_sync1_q;
    btn_sync1_d  = btn;
    btn_sync2_d  = btn_sync1_q;
    btn_stable_d = btn_stable_q;
    cnt_d        = cnt_q;
    if (btn_sync2_q == btn_stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      btn_stable_d = btn_sync2_q;
      cnt_d        = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Only the rising edge of the debounced level counts as a press.
  assign press = btn_stable_d & ~btn_stable_q;

  always_comb begin
    state_d  = state_q;
    addend_d = addend_q;
    augend_d = augend_q;
    valid_d  = valid_q;
    case (state_q)
      ENTER_ADDEND: begin
        if (press) begin
          addend_d = sw_sync2_q;
          state_d  = ENTER_AUGEND;
        end
      end
      ENTER_AUGEND: begin
        if (press) begin
          augend_d = sw_sync2_q[0];
          valid_d  = 1'b1;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (press) begin
          addend_d = '0;
          augend_d = 1'b0;
          valid_d  = 1'b0;
          state_d  = ENTER_ADDEND;
        end
      end
      default: begin
        addend_d = '0;
        augend_d = 1'b0;
        valid_d  = 1'b0;
        state_d  = ENTER_ADDEND;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync1_q   <= '0;
      sw_sync2_q   <= '0;
      btn_sync1_q  <= 1'b0;
      btn_sync2_q  <= 1'b0;
      btn_stable_q <= 1'b0;
      cnt_q        <= '0;
      state_q      <= ENTER_ADDEND;
      addend_q     <= '0;
      augend_q     <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      sw_sync1_q   <= sw_sync1_d;
      sw_sync2_q   <= sw_sync2_d;
      btn_sync1_q  <= btn_sync1_d;
      btn_sync2_q  <= btn_sync2_d;
      btn_stable_q <= btn_stable_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      addend_q     <= addend_d;
      augend_q     <= augend_d;
      valid_q      <= valid_d;
    end
  end

  assign addend         = addend_q;
  assign augend         = augend_q;
  assign operands_valid = valid_q;
  assign state_led      = state_q;

endmodule

// File: tb/tb_lab2_operand_entry.sv
// Directed bench for lab2_operand_entry with DEBOUNCE_CYCLES=4.
// Outputs are packed as {state_led, addend, augend, operands_valid}.
module tb_lab2_operand_entry;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       btn;
  logic [1:0] addend;
  logic       augend;
  logic       operands_valid;
  logic [1:0] state_led;

  int n_assert = 0;
  int n_fail   = 0;

  logic [5:0] sb[$];

  lab2_operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk            (clk),
    .rst            (rst),
    .sw             (sw),
    .btn            (btn),
    .addend         (addend),
    .augend         (augend),
    .operands_valid (operands_valid),
    .state_led      (state_led)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {state_led, addend, augend, operands_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs,
                     input logic [5:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_change(input string tag, input int budget);
    logic [5:0] prev;
    logic       got;
    prev = outs();
    got  = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (outs() !== prev) got = 1'b1;
    end
    chk({tag, "_seen"}, {5'b0, got}, 6'b1);
    if (got && sb.size() > 0) chk(tag, outs(), sb.pop_front());
  endtask

  task automatic press(input string tag, input logic [1:0] sv,
                       input logic [5:0] exp);
    sw = sv;
    repeat (3) tick();
    sb.push_back(exp);
    btn = 1'b1;
    wait_change(tag, 12);
    btn = 1'b0;
    repeat (10) tick();
  endtask

  int         changes;
  logic [5:0] prev_o;

  task automatic mon_tick();
    tick();
    if (outs() !== prev_o) changes++;
    prev_o = outs();
  endtask

  initial begin
    rst = 1'b1;
    sw  = 2'b00;
    btn = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset", outs(), 6'b00_00_0_0);

    // latency: first sampled at E0, capture at exactly E0+5
    sw = 2'b10;
    repeat (3) tick();
    sb.push_back(6'b01_10_0_0);
    btn = 1'b1;
    repeat (5) tick();
    chk("lat_e4", outs(), 6'b00_00_0_0);
    tick();
    chk("lat_e5", outs(), sb.pop_front());
    btn = 1'b0;
    repeat (10) tick();

    // one-cycle reset while in ENTER_AUGEND with addend=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", outs(), 6'b00_00_0_0);

    press("entry_add", 2'b11, 6'b01_11_0_0);
    press("entry_aug", 2'b01, 6'b10_11_1_1);

    // switches must not disturb captured operands in SHOW
    for (int v = 0; v < 4; v++) begin
      sw = 2'(v);
      repeat (4) tick();
      chk($sformatf("iso_sw%0d", v), outs(), 6'b10_11_1_1);
    end

    press("entry_clr", 2'b10, 6'b00_00_0_0);

    // bounce: 3 high, 1 low, 3 high, then low
    changes = 0;
    prev_o  = outs();
    btn = 1'b1;
    repeat (3) mon_tick();
    btn = 1'b0;
    mon_tick();
    btn = 1'b1;
    repeat (3) mon_tick();
    btn = 1'b0;
    repeat (10) mon_tick();
    chk("bounce_nochg", 6'(changes), 6'd0);
    chk("bounce_out", outs(), 6'b00_00_0_0);
    chk("bounce_cnt", 6'(dut.cnt_q), 6'd0);

    // held button: exactly one event
    sw = 2'b01;
    repeat (3) tick();
    sb.push_back(6'b01_01_0_0);
    changes = 0;
    prev_o  = outs();
    btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (outs() !== prev_o) begin
        changes++;
        if (sb.size() > 0) chk("held_evt", outs(), sb.pop_front());
      end
      prev_o = outs();
    end
    chk("held_count", 6'(changes), 6'd1);
    btn = 1'b0;
    repeat (10) tick();

    // reset coinciding with the press edge wins; event restarts after
    sw = 2'b10;
    repeat (3) tick();
    btn = 1'b1;
    repeat (5) tick();
    chk("prio_e4", outs(), 6'b01_01_0_0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("prio_rst", outs(), 6'b00_00_0_0);
    sb.push_back(6'b01_10_0_0);
    repeat (5) tick();
    chk("rel_e4", outs(), 6'b00_00_0_0);
    tick();
    if (sb.size() > 0) chk("rel_e5", outs(), sb.pop_front());
    btn = 1'b0;
    repeat (10) tick();

    chk("sb_empty", 6'(sb.size()), 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_operand_entry.md
LAB2_OPERAND_ENTRY -- requirements
Module: lab2_operand_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 20, consecutive clk cycles the synchronized button must differ from its debounced level before that level changes (minimum 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sw  input  2  raw operand switches, asynchronous to clk.
REQ-005 btn  input  1  raw enter push-button, asynchronous and bouncing, active-high.
REQ-006 addend  output  2  captured addend, registered.
REQ-007 augend  output  1  captured augend, registered.
REQ-008 operands_valid  output  1  high while both operands are captured and stable for the downstream adder.
REQ-009 state_led  output  2  current FSM state encoding, for board LEDs.

Function
REQ-010 sw and btn SHALL each pass through a two-flop synchronizer (sync1, then sync2); only sync2 values are used internally.
REQ-011 Debouncer: if btn_sync2 == btn_stable, counter SHALL load 0; otherwise, if counter == DEBOUNCE_CYCLES-1, btn_stable SHALL take btn_sync2 and counter SHALL load 0; otherwise counter SHALL increment.
REQ-012 A press event SHALL be the single edge at which btn_stable changes 0->1; a 1->0 change SHALL generate no event.
REQ-013 With btn first sampled high at edge E0 and held high, the press event SHALL occur at edge E0+DEBOUNCE_CYCLES+1.
REQ-014 Any return of btn_sync2 to btn_stable before the count completes SHALL zero the counter and produce no event.
REQ-015 FSM states, with state_led encoding: ENTER_ADDEND=2'b00, ENTER_AUGEND=2'b01, SHOW=2'b10; 2'b11 is unreachable and SHALL return to ENTER_ADDEND on the next edge.
REQ-016 ENTER_ADDEND + press event: addend <= sw_sync2[1:0]; next state ENTER_AUGEND.
REQ-017 ENTER_AUGEND + press event: augend <= sw_sync2[0]; next state SHOW; operands_valid rises at the same edge.
REQ-018 SHOW + press event: addend <= 0, augend <= 0, operands_valid <= 0; next state ENTER_ADDEND.
REQ-019 With no press event, state, addend, augend and operands_valid SHALL hold.
REQ-020 operands_valid SHALL be 1 exactly when state is SHOW.
REQ-021 Switch changes SHALL never alter addend or augend except at a press event in the relevant state.
REQ-022 Holding btn high indefinitely SHALL produce exactly one event; a further event requires a debounced release followed by a new debounced press.
REQ-023 The counter width SHALL hold DEBOUNCE_CYCLES-1 without wrap-around.

Reset
REQ-024 When rst is high at a rising edge, the block SHALL set: state ENTER_ADDEND, addend 0, augend 0, operands_valid 0, state_led 2'b00, counter 0, btn_stable 0, all synchronizer flops 0.
REQ-025 rst SHALL take priority over a press event coinciding at the same edge; that event SHALL be lost.
REQ-026 rst asserted mid-debounce or in any state SHALL abort the operation with no partial capture retained.
REQ-027 After rst deasserts with btn still high, one press event SHALL follow per REQ-013, counted from the first edge with rst low.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Bench SHALL cover entry sequence: sw=2'b11 with a clean press, then sw=2'b01 with a clean press -> addend=3, augend=1, operands_valid=1, state_led=2'b10; a third press -> all outputs 0, state_led=2'b00.
REQ-029 Bench SHALL cover latency: btn high at edge E0 -> state_led changes at exactly E0+5, not at E0+4.
REQ-030 Bench SHALL cover bounce: btn high 3 cycles, low 1 cycle, high 3 cycles, then low -> no state change, counter returns to 0.
REQ-031 Bench SHALL cover held button: btn high for 50 cycles -> exactly one transition, 00->01.
REQ-032 Bench SHALL cover reset mid-operation: in ENTER_AUGEND with addend=2, assert rst for 1 cycle -> addend=0, state_led=2'b00, operands_valid=0.
REQ-033 Bench SHALL cover switch isolation: in SHOW, toggle sw through all 4 values without a press -> addend, augend and operands_valid unchanged.
